// File: rtl/video_timing_generator.sv
// Video timing generator: free-running h/v raster counters with registered
// sync, blanking and pixel-pipeline strobes, all aligned to the current (h,v).
module video_timing_generator #(
  parameter int unsigned H_ACTIVE        = 1024,
  parameter int unsigned H_FRONT         = 24,
  parameter int unsigned H_PULSE         = 136,
  parameter int unsigned H_BACK          = 160,
  parameter int unsigned V_ACTIVE        = 768,
  parameter int unsigned V_FRONT         = 3,
  parameter int unsigned V_PULSE         = 6,
  parameter int unsigned V_BACK          = 29,
  parameter int unsigned V_VISIBLE       = 600,
  parameter bit          HSYNC_POL       = 1'b0,
  parameter bit          VSYNC_POL       = 1'b0,
  parameter int unsigned PIXEL_LEAD      = 4,
  parameter int unsigned PREFETCH_STROBE = 4,
  localparam int unsigned H_TOTAL        = H_ACTIVE + H_FRONT + H_PULSE + H_BACK,
  localparam int unsigned V_TOTAL        = V_ACTIVE + V_FRONT + V_PULSE + V_BACK,
  localparam int unsigned HW             = $clog2(H_TOTAL),
  localparam int unsigned VW             = $clog2(V_TOTAL)
) (
  input  logic          i_pixel_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_blank,
  output logic          o_pixel_first,
  output logic          o_pixel_last,
  output logic          o_prefetch_start,
  output logic          o_prefetch_strobe_end,
  output logic          o_switch_allowed,
  output logic          o_row_first_render,
  output logic          o_row_last_render,
  output logic          o_frame_start,
  output logic [7:0]    o_frame_count,
  output logic [HW-1:0] o_counter_h,
  output logic [VW-1:0] o_counter_v
);

  // Visible window bounds (inclusive).
  localparam int unsigned HS = H_PULSE + H_BACK;
  localparam int unsigned HE = HS + H_ACTIVE - 1;
  localparam int unsigned VS = V_PULSE + V_BACK;
  localparam int unsigned VE = VS + V_VISIBLE - 1;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_PULSE);
  localparam logic [HW-1:0] H_START     = HW'(HS);
  localparam logic [HW-1:0] H_END       = HW'(HE);
  localparam logic [HW-1:0] H_PIX_FIRST = HW'(HS - PIXEL_LEAD);
  localparam logic [HW-1:0] H_PIX_LAST  = HW'(HE - PIXEL_LEAD);
  localparam logic [HW-1:0] H_PF_START  = HW'(HE + 1);
  localparam logic [HW-1:0] H_PF_END    = HW'(HE + 1 + PREFETCH_STROBE);

  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_PULSE);
  localparam logic [VW-1:0] V_START     = VW'(VS);
  localparam logic [VW-1:0] V_END       = VW'(VE);
  localparam logic [VW-1:0] V_ROW_FIRST = VW'(VS - 1);
  localparam logic [VW-1:0] V_ROW_LAST  = VW'(VE - 1);

  // Elaboration-time sanity checks on the timing parameters.
  if (PIXEL_LEAD >= HS) begin : g_chk_lead
    $fatal(1, "PIXEL_LEAD must be smaller than H_PULSE + H_BACK");
  end
  if (HE + 1 + PREFETCH_STROBE >= H_TOTAL) begin : g_chk_prefetch
    $fatal(1, "prefetch strobe window must end before the line wraps");
  end
  if (VS < 1) begin : g_chk_vs
    $fatal(1, "V_PULSE + V_BACK must be at least 1");
  end
  if (V_VISIBLE < 1 || V_VISIBLE > V_ACTIVE) begin : g_chk_visible
    $fatal(1, "V_VISIBLE must lie in 1..V_ACTIVE");
  end

  logic          r_run;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [7:0]    r_frame_count;
  logic          r_hsync, r_vsync, r_blank;
  logic          r_pixel_first, r_pixel_last, r_prefetch_start, r_prefetch_strobe_end;
  logic          r_switch_allowed, r_row_first_render, r_row_last_render, r_frame_start;

  logic          w_run_next;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic [7:0]    w_frame_count_next;
  logic          w_h_vis, w_v_vis;

  // Next raster position: idle parks at (0,0); the first enabled cycle shows (0,0).
  always_comb begin
    w_run_next         = i_enable;
    w_h_next           = '0;
    w_v_next           = '0;
    w_frame_count_next = r_frame_count;
    if (i_enable && r_run) begin
      if (r_h == H_LAST) begin
        if (r_v == V_LAST) begin
          w_frame_count_next = r_frame_count + 8'd1;
        end else begin
          w_v_next = r_v + 1'b1;
        end
      end else begin
        w_h_next = r_h + 1'b1;
        w_v_next = r_v;
      end
    end
  end

  // Visible-window qualifiers for the upcoming position.
  always_comb begin
    w_h_vis = (w_h_next >= H_START) && (w_h_next <= H_END);
    w_v_vis = (w_v_next >= V_START) && (w_v_next <= V_END);
  end

  // Raster state and outputs, registered from the next-state decode.
  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) begin
      r_run                 <= 1'b0;
      r_h                   <= '0;
      r_v                   <= '0;
      r_frame_count         <= 8'd0;
      r_hsync               <= ~HSYNC_POL;
      r_vsync               <= ~VSYNC_POL;
      r_blank               <= 1'b1;
      r_pixel_first         <= 1'b0;
      r_pixel_last          <= 1'b0;
      r_prefetch_start      <= 1'b0;
      r_prefetch_strobe_end <= 1'b0;
      r_switch_allowed      <= 1'b0;
      r_row_first_render    <= 1'b0;
      r_row_last_render     <= 1'b0;
      r_frame_start         <= 1'b0;
    end else begin
      r_run                 <= w_run_next;
      r_h                   <= w_h_next;
      r_v                   <= w_v_next;
      r_frame_count         <= w_frame_count_next;
      r_hsync               <= (w_run_next && (w_h_next < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync               <= (w_run_next && (w_v_next < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
      r_blank               <= ~(w_run_next && w_h_vis && w_v_vis);
      r_pixel_first         <= w_run_next && w_v_vis && (w_h_next == H_PIX_FIRST);
      r_pixel_last          <= w_run_next && w_v_vis && (w_h_next == H_PIX_LAST);
      r_prefetch_start      <= w_run_next && (w_h_next == H_PF_START);
      r_prefetch_strobe_end <= w_run_next && (w_h_next == H_PF_END);
      r_switch_allowed      <= w_run_next && (w_h_next == H_PF_START) && (w_v_next == V_END);
      r_row_first_render    <= w_run_next && (w_v_next == V_ROW_FIRST);
      r_row_last_render     <= w_run_next && (w_v_next == V_ROW_LAST);
      r_frame_start         <= w_run_next && (w_h_next == '0) && (w_v_next == '0);
    end
  end

  assign o_hsync               = r_hsync;
  assign o_vsync               = r_vsync;
  assign o_blank               = r_blank;
  assign o_pixel_first         = r_pixel_first;
  assign o_pixel_last          = r_pixel_last;
  assign o_prefetch_start      = r_prefetch_start;
  assign o_prefetch_strobe_end = r_prefetch_strobe_end;
  assign o_switch_allowed      = r_switch_allowed;
  assign o_row_first_render    = r_row_first_render;
  assign o_row_last_render     = r_row_last_render;
  assign o_frame_start         = r_frame_start;
  assign o_frame_count         = r_frame_count;
  assign o_counter_h           = r_h;
  assign o_counter_v           = r_v;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench: a shrunken raster checked cycle by cycle against hand-derived
// positions, plus a default-parameter instance checked over its first line.
module tb_video_timing_generator;

  // Small raster: H total 17 (HS=7, HE=14), V total 12 (VS=5, VE=8).
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;

  logic       s_hsync, s_vsync, s_blank, s_pf, s_pl, s_ps, s_pse, s_sw, s_rf, s_rl, s_fs;
  logic [7:0] s_fc;
  logic [4:0] s_h;
  logic [3:0] s_v;

  logic       d_hsync, d_vsync, d_blank, d_pf, d_pl, d_ps, d_pse, d_sw, d_rf, d_rl, d_fs;
  logic [7:0] d_fc;
  logic [10:0] d_h;
  logic [9:0]  d_v;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state for the small raster.
  int unsigned m_h = 0, m_v = 0, m_fc = 0;
  bit          m_run = 1'b0;

  always #5 clk = ~clk;

  video_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(4),
    .V_ACTIVE(6), .V_FRONT(1), .V_PULSE(2), .V_BACK(3),
    .V_VISIBLE(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .PIXEL_LEAD(2), .PREFETCH_STROBE(1)
  ) u_dut (
    .i_pixel_clk(clk), .i_reset(rst), .i_enable(en),
    .o_hsync(s_hsync), .o_vsync(s_vsync), .o_blank(s_blank),
    .o_pixel_first(s_pf), .o_pixel_last(s_pl),
    .o_prefetch_start(s_ps), .o_prefetch_strobe_end(s_pse),
    .o_switch_allowed(s_sw), .o_row_first_render(s_rf), .o_row_last_render(s_rl),
    .o_frame_start(s_fs), .o_frame_count(s_fc),
    .o_counter_h(s_h), .o_counter_v(s_v)
  );

  video_timing_generator u_dut_def (
    .i_pixel_clk(clk), .i_reset(rst), .i_enable(en),
    .o_hsync(d_hsync), .o_vsync(d_vsync), .o_blank(d_blank),
    .o_pixel_first(d_pf), .o_pixel_last(d_pl),
    .o_prefetch_start(d_ps), .o_prefetch_strobe_end(d_pse),
    .o_switch_allowed(d_sw), .o_row_first_render(d_rf), .o_row_last_render(d_rl),
    .o_frame_start(d_fs), .o_frame_count(d_fc),
    .o_counter_h(d_h), .o_counter_v(d_v)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t h=%0d v=%0d)", tag, got, exp, $time,
               m_h, m_v);
    end
  endtask

  // Advance one clock; update the reference model from the sampled inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_h = 0; m_v = 0; m_fc = 0;
    end else if (!en) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_h = 0; m_v = 0;
    end else if (m_h == 16) begin
      m_h = 0;
      if (m_v == 11) begin
        m_v = 0;
        m_fc = (m_fc + 1) % 256;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
    #1;
  endtask

  task automatic check_small();
    bit vis;
    vis = (m_v >= 5) && (m_v <= 8);
    chk("counter_h", s_h, m_h);
    chk("counter_v", s_v, m_v);
    chk("hsync", s_hsync, (m_run && m_h < 3) ? 1 : 0);
    chk("vsync", s_vsync, (m_run && m_v < 2) ? 0 : 1);
    chk("blank", s_blank, (m_run && vis && m_h >= 7 && m_h <= 14) ? 0 : 1);
    chk("pixel_first", s_pf, (m_run && vis && m_h == 5) ? 1 : 0);
    chk("pixel_last", s_pl, (m_run && vis && m_h == 12) ? 1 : 0);
    chk("prefetch_start", s_ps, (m_run && m_h == 15) ? 1 : 0);
    chk("prefetch_end", s_pse, (m_run && m_h == 16) ? 1 : 0);
    chk("switch_allowed", s_sw, (m_run && m_h == 15 && m_v == 8) ? 1 : 0);
    chk("row_first", s_rf, (m_run && m_v == 4) ? 1 : 0);
    chk("row_last", s_rl, (m_run && m_v == 7) ? 1 : 0);
    chk("frame_start", s_fs, (m_run && m_h == 0 && m_v == 0) ? 1 : 0);
    chk("frame_count", s_fc, m_fc);
  endtask

  initial begin
    // Reset with enable low, then enable already high while reset is held.
    tick();
    tick();
    check_small();
    chk("def_reset_hsync", d_hsync, 1);
    chk("def_reset_blank", d_blank, 1);
    en = 1'b1;
    tick();
    check_small();
    rst = 1'b0;

    // First line of the default raster (1344 clocks) alongside the small raster.
    for (int i = 0; i <= 1344; i++) begin
      tick();
      check_small();
      chk("def_counter_h", d_h, (i < 1344) ? i : 0);
      chk("def_counter_v", d_v, (i < 1344) ? 0 : 1);
      chk("def_hsync", d_hsync, (i < 136 || i == 1344) ? 0 : 1);
      chk("def_frame_start", d_fs, (i == 0) ? 1 : 0);
    end

    // Drop enable mid-frame, then re-enable.
    while (!(m_h == 10 && m_v == 6)) begin
      tick();
      check_small();
    end
    en = 1'b0;
    tick();
    check_small();
    chk("drop_idle_h", s_h, 0);
    tick();
    check_small();
    en = 1'b1;
    tick();
    check_small();
    chk("reenable_fs", s_fs, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_small();
    end

    // Asynchronous reset mid-line, no clock edge in between.
    chk("pre_reset_fc_nonzero", (s_fc != 0) ? 1 : 0, 1);
    #2;
    rst = 1'b1;
    #1;
    m_run = 1'b0; m_h = 0; m_v = 0; m_fc = 0;
    check_small();
    chk("def_async_h", d_h, 0);
    chk("def_async_fc", d_fc, 0);
    rst = 1'b0;

    // 256+ frames so the frame counter wraps.
    for (int i = 0; i < 256 * 204 + 20; i++) begin
      tick();
      check_small();
    end
    chk("wrapped_fc", s_fc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
